// File: rtl/tm1638_sched.sv
// tm1638_sched
//   Owns the TM1638 byte engine and shares it between a key-scan requester and
//   a display-refresh requester. Builds CS framing, command bytes and the
//   read/write direction, streams the 16-byte display frame from a caller
//   buffer, and returns the decoded key state.
// Ports
//   clkIn, rst            : clock, synchronous active-high reset
//   key_req/key_ack/keys  : key-scan handshake (level req, pulse ack) and result
//   disp_req/disp_ack     : display-refresh handshake
//   frame_addr/frame_byte : display buffer read port (combinational data)
//   disp_on, bright       : display-control fields, sampled at the control byte
//   err                   : one-cycle pulse when the engine fails to go busy
//   tm_cs/tm_rw/tm_latch/tm_out : to the engine (tm_rw 1 = write)
//   busy, tm_in           : from the engine
module tm1638_sched #(
  parameter int CS_GAP      = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       key_req,
  output logic       key_ack,
  output logic [7:0] keys,
  input  logic       disp_req,
  output logic       disp_ack,
  output logic [3:0] frame_addr,
  input  logic [7:0] frame_byte,
  input  logic       disp_on,
  input  logic [2:0] bright,
  output logic       err,
  output logic       tm_cs,
  output logic       tm_rw,
  output logic       tm_latch,
  output logic [7:0] tm_out,
  input  logic       busy,
  input  logic [7:0] tm_in
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {IDLE, ARB, CS_SETUP, ISSUE, WAIT_ACK, WAIT_DONE, CS_END, GAP} state_t;

  state_t        r_state;
  logic          r_tx;       // 0 = key scan, 1 = display
  logic          r_last;     // last granted transaction, 1 = display
  logic [1:0]    r_frame;
  logic [4:0]    r_cnt;      // byte index within the current frame
  logic          r_more;     // another frame of this transaction follows the gap
  logic [TW-1:0] r_to;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_kshadow;  // key bits gathered during the scan frame
  logic          r_cs, r_rw, r_latch, r_kack, r_dack, r_err;
  logic [7:0]    r_out, r_keys;
  logic [3:0]    r_addr;

  logic [4:0] w_idx;
  logic [7:0] w_byte, w_kcap;
  logic       w_rw, w_data, w_lastb, w_lastfr, w_gkey;
  logic [1:0] w_ri;
  logic       w_unused;

  assign w_unused = ^{tm_in[7:5], tm_in[3:1]};
  assign w_gkey   = key_req && (!disp_req || r_last);

  always_comb begin
    // Index of the byte about to be launched: 0 out of CS_SETUP, next one out of WAIT_DONE.
    w_idx    = (r_state == WAIT_DONE) ? r_cnt + 5'd1 : 5'd0;
    w_rw     = !(!r_tx && w_idx != 5'd0);
    w_data   = r_tx && r_frame == 2'd1 && w_idx != 5'd0;
    w_byte   = 8'h00;
    if (!r_tx) w_byte = (w_idx == 5'd0) ? 8'h42 : 8'h00;
    else begin
      case (r_frame)
        2'd0:    w_byte = 8'h40;
        2'd1:    w_byte = w_data ? frame_byte : 8'hC0;
        default: w_byte = {4'b1000, disp_on, bright};
      endcase
    end
    w_lastb  = r_tx ? ((r_frame == 2'd1) ? (r_cnt == 5'd16) : (r_cnt == 5'd0)) : (r_cnt == 5'd4);
    w_lastfr = !r_tx || r_frame == 2'd2;
    // Read i = r_cnt-1 carries S(8-i) in bit 0 and S(4-i) in bit 4.
    w_ri     = r_cnt[1:0] - 2'd1;
    w_kcap   = r_kshadow;
    w_kcap[3'd7 - {1'b0, w_ri}] = tm_in[0];
    w_kcap[3'd3 - {1'b0, w_ri}] = tm_in[4];
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      r_state <= IDLE; r_tx <= 1'b0; r_last <= 1'b1; r_frame <= 2'd0; r_cnt <= 5'd0;
      r_more <= 1'b0; r_to <= '0; r_gap <= '0; r_kshadow <= 8'h00;
      r_cs <= 1'b1; r_rw <= 1'b1; r_latch <= 1'b0; r_out <= 8'h00; r_keys <= 8'h00;
      r_kack <= 1'b0; r_dack <= 1'b0; r_err <= 1'b0; r_addr <= 4'd0;
    end else begin
      r_latch <= 1'b0;
      r_kack  <= 1'b0;
      r_dack  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (key_req || disp_req) r_state <= ARB;
        ARB: begin
          // A request that went away before the grant is simply dropped.
          if (key_req || disp_req) begin
            r_tx    <= !w_gkey;
            r_last  <= !w_gkey;
            r_frame <= 2'd0;
            r_cnt   <= 5'd0;
            r_cs    <= 1'b0;
            r_state <= CS_SETUP;
          end else r_state <= IDLE;
        end
        CS_SETUP: begin
          r_state <= ISSUE;
          r_latch <= 1'b1;
          r_out   <= w_byte;
          r_rw    <= w_rw;
        end
        ISSUE: begin
          r_state <= WAIT_ACK;
          r_to    <= TW'(1);
        end
        WAIT_ACK: begin
          if (busy) r_state <= WAIT_DONE;
          else if (r_to == TW'(ACK_TIMEOUT - 1)) begin
            // Engine never started: close the frame, leave the request pending.
            r_cs    <= 1'b1;
            r_rw    <= 1'b1;
            r_err   <= 1'b1;
            r_addr  <= 4'd0;
            r_more  <= 1'b0;
            r_gap   <= '0;
            r_state <= GAP;
          end else r_to <= r_to + TW'(1);
        end
        WAIT_DONE: begin
          if (!busy) begin
            if (!r_tx && r_cnt != 5'd0) r_kshadow <= w_kcap;
            if (w_lastb) begin
              r_cs    <= 1'b1;
              r_rw    <= 1'b1;
              r_state <= CS_END;
              if (w_lastfr) begin
                r_more <= 1'b0;
                if (r_tx) r_dack <= 1'b1;
                else begin
                  r_kack <= 1'b1;
                  r_keys <= w_kcap;
                end
              end else begin
                r_more  <= 1'b1;
                r_frame <= r_frame + 2'd1;
              end
            end else begin
              r_cnt   <= r_cnt + 5'd1;
              r_state <= ISSUE;
              r_latch <= 1'b1;
              r_out   <= w_byte;
              r_rw    <= w_rw;
              // Advance the buffer index so it is settled the cycle before the next latch;
              // the 4-bit wrap after byte 15 returns it to 0 for idle.
              if (w_data) r_addr <= r_addr + 4'd1;
            end
          end
        end
        CS_END: begin
          r_gap   <= '0;
          r_state <= GAP;
        end
        GAP: begin
          if (r_gap == GW'(CS_GAP - 1)) begin
            if (r_more) begin
              r_cs    <= 1'b0;
              r_cnt   <= 5'd0;
              r_state <= CS_SETUP;
            end else r_state <= IDLE;
          end else r_gap <= r_gap + GW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tm_cs      = r_cs;
  assign tm_rw      = r_rw;
  assign tm_latch   = r_latch;
  assign tm_out     = r_out;
  assign keys       = r_keys;
  assign key_ack    = r_kack;
  assign disp_ack   = r_dack;
  assign err        = r_err;
  assign frame_addr = r_addr;
endmodule

// File: tb/tb_tm1638_sched.sv
// Bench for tm1638_sched: a behavioural TM1638 engine, a protocol monitor and
// per-scenario tasks comparing byte streams and key results to a frame-level model.
module tb_tm1638_sched;
  localparam int GAP_MIN = 2;

  logic       clkIn = 1'b0;
  logic       rst, key_req, disp_req, disp_on;
  logic [2:0] bright;
  logic       key_ack, disp_ack, err, tm_cs, tm_rw, tm_latch;
  logic [7:0] keys, tm_out, frame_byte;
  logic [3:0] frame_addr;
  logic       busy = 1'b0;
  logic [7:0] tm_in = 8'h00;
  logic [7:0] fbuf [16];

  always #5 clkIn = ~clkIn;
  assign frame_byte = fbuf[frame_addr];

  tm1638_sched #(.CS_GAP(2), .ACK_TIMEOUT(8)) dut (
    .clkIn(clkIn), .rst(rst), .key_req(key_req), .key_ack(key_ack), .keys(keys),
    .disp_req(disp_req), .disp_ack(disp_ack), .frame_addr(frame_addr),
    .frame_byte(frame_byte), .disp_on(disp_on), .bright(bright), .err(err),
    .tm_cs(tm_cs), .tm_rw(tm_rw), .tm_latch(tm_latch), .tm_out(tm_out),
    .busy(busy), .tm_in(tm_in));

  int n_cmp = 0, n_bad = 0;

  // Engine model: busy rises 1..3 cycles after a latch, stays up 1..3 cycles.
  bit         stall = 1'b0;
  logic [7:0] rdq [$];
  int         e_pre = 0, e_bsy = 0;
  bit         e_act = 1'b0;
  always @(posedge clkIn) begin
    if (rst) begin
      busy <= 1'b0; e_act <= 1'b0;
    end else if (tm_latch && !stall) begin
      e_act <= 1'b1;
      e_pre <= $urandom_range(0, 2);
      e_bsy <= $urandom_range(1, 3);
      if (!tm_rw) tm_in <= (rdq.size() > 0) ? rdq.pop_front() : 8'($urandom);
    end else if (e_act) begin
      if (e_pre > 0) e_pre <= e_pre - 1;
      else if (!busy) busy <= 1'b1;
      else if (e_bsy > 1) e_bsy <= e_bsy - 1;
      else begin busy <= 1'b0; e_act <= 1'b0; end
    end
  end

  // Protocol monitor: counts pulses/frames, logs latched bytes, tallies rule violations.
  typedef struct { int fr; logic rw; logic [7:0] b; } ent_t;
  ent_t       lg [$];
  int         viol = 0, n_kack = 0, n_dack = 0, n_err = 0, fr_id = 0, hi_cnt = 100;
  logic       p_cs = 1'b1, p_rw = 1'b1, p_latch = 1'b0, p_busy = 1'b0;
  logic [7:0] p_keys = 8'h00;
  always @(negedge clkIn) begin
    if (rst) begin
      hi_cnt <= 100;
    end else begin
      viol <= viol + int'(tm_latch && (busy || tm_cs)) + int'(tm_cs && !tm_rw)
                   + int'(key_ack && disp_ack)
                   + int'((key_ack || disp_ack) && !(tm_cs && !p_cs))
                   + int'(tm_rw != p_rw && (p_latch || p_busy))
                   + int'(keys != p_keys && !key_ack)
                   + int'(!tm_cs && p_cs && hi_cnt < GAP_MIN);
      if (tm_cs) hi_cnt <= hi_cnt + 1; else hi_cnt <= 0;
      if (!tm_cs && p_cs) fr_id <= fr_id + 1;
      if (tm_latch) lg.push_back('{fr_id, tm_rw, tm_out});
      n_kack <= n_kack + int'(key_ack);
      n_dack <= n_dack + int'(disp_ack);
      n_err  <= n_err + int'(err);
    end
    p_cs <= tm_cs; p_rw <= tm_rw; p_latch <= tm_latch; p_busy <= busy; p_keys <= keys;
  end

  function automatic logic [7:0] key_model(input logic [7:0] v0, v1, v2, v3);
    logic [7:0] v [4];
    logic [7:0] k;
    v = '{v0, v1, v2, v3};
    k = 8'h00;
    for (int i = 0; i < 4; i++) begin
      k[7-i] = v[i][0];
      k[3-i] = v[i][4];
    end
    return k;
  endfunction

  localparam logic [26:0] RST_VEC = {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0};

  task automatic test_reset();
    rst = 1'b1; key_req = 1'b0; disp_req = 1'b0;
    repeat (3) @(negedge clkIn);
    n_cmp++;
    if ({tm_cs, tm_rw, tm_latch, tm_out, keys, key_ack, disp_ack, err, frame_addr} !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want %h",
               {tm_cs, tm_rw, tm_latch, tm_out, keys, key_ack, disp_ack, err, frame_addr}, RST_VEC);
    end
    rst = 1'b0;
    repeat (3) @(negedge clkIn);
  endtask

  task automatic test_key_scan();
    logic [7:0] fx [4];
    logic [7:0] v [4];
    logic [7:0] ek;
    logic [1:0] csv;
    int fr0, ka0;
    bit got, ok;
    fx = '{8'h01, 8'h10, 8'h00, 8'h11};
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) v[i] = (r == 0) ? fx[i] : 8'($urandom);
      ek = key_model(v[0], v[1], v[2], v[3]);
      rdq.delete(); lg.delete();
      for (int i = 0; i < 4; i++) rdq.push_back(v[i]);
      fr0 = fr_id; ka0 = n_kack; got = 0;
      key_req = 1'b1;
      @(negedge clkIn); csv[1] = tm_cs;
      @(negedge clkIn); csv[0] = tm_cs;
      n_cmp++;
      if (csv !== 2'b10) begin n_bad++; $display("FAIL key_cs_latency round %0d got %b want 10", r, csv); end
      for (int c = 0; c < 300; c++) begin
        if (key_ack) begin got = 1; break; end
        @(negedge clkIn);
      end
      n_cmp++;
      if (!got || keys !== ek) begin
        n_bad++; $display("FAIL key_value round %0d acked=%0d got %h want %h", r, got, keys, ek);
      end
      key_req = 1'b0;
      repeat (6) @(negedge clkIn);
      n_cmp++;
      if (n_kack - ka0 !== 1) begin n_bad++; $display("FAIL key_ack_count round %0d got %0d want 1", r, n_kack - ka0); end
      ok = (lg.size() == 5);
      for (int i = 0; i < lg.size() && i < 5; i++)
        if (lg[i].fr != fr0 + 1 || lg[i].rw !== (i == 0) || (i == 0 && lg[i].b !== 8'h42)) ok = 0;
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL key_bytes round %0d got %0d latches want 5 (0x42 write + 4 reads, one frame)", r, lg.size());
      end
    end
  endtask

  task automatic test_display();
    ent_t exp [$];
    int fr0, da0, bad_i;
    bit got;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) fbuf[i] = (r == 0) ? 8'(i) : 8'($urandom);
      disp_on = (r == 0) ? 1'b1 : 1'($urandom);
      bright  = (r == 0) ? 3'd7 : 3'($urandom);
      lg.delete(); exp.delete();
      fr0 = fr_id; da0 = n_dack; got = 0;
      exp.push_back('{fr0 + 1, 1'b1, 8'h40});
      exp.push_back('{fr0 + 2, 1'b1, 8'hC0});
      for (int i = 0; i < 16; i++) exp.push_back('{fr0 + 2, 1'b1, fbuf[i]});
      exp.push_back('{fr0 + 3, 1'b1, 8'h80 + 8'(disp_on) * 8'd8 + 8'(bright)});
      disp_req = 1'b1;
      for (int c = 0; c < 800; c++) begin
        @(negedge clkIn);
        if (disp_ack) begin got = 1; break; end
      end
      disp_req = 1'b0;
      repeat (6) @(negedge clkIn);
      n_cmp++;
      if (!got || n_dack - da0 !== 1) begin
        n_bad++; $display("FAIL disp_ack_count round %0d got %0d want 1", r, n_dack - da0);
      end
      bad_i = (lg.size() == exp.size()) ? -1 : 99;
      for (int i = 0; i < lg.size() && i < exp.size(); i++)
        if (bad_i < 0 && (lg[i].fr != exp[i].fr || lg[i].rw !== exp[i].rw || lg[i].b !== exp[i].b)) bad_i = i;
      n_cmp++;
      if (bad_i >= 0) begin
        n_bad++;
        $display("FAIL disp_bytes round %0d first bad entry %0d, %0d latches want %0d, entry byte %h want %h",
                 r, bad_i, lg.size(), exp.size(),
                 (bad_i < lg.size()) ? lg[bad_i].b : 8'hxx, (bad_i < exp.size()) ? exp[bad_i].b : 8'hxx);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [8];
    logic [7:0] ek1, ek2;
    logic [15:0] kk;
    logic [3:0] ord;
    int na, nk;
    rst = 1'b1; repeat (2) @(negedge clkIn); rst = 1'b0;
    rdq.delete();
    for (int i = 0; i < 8; i++) begin v[i] = 8'($urandom); rdq.push_back(v[i]); end
    ek1 = key_model(v[0], v[1], v[2], v[3]);
    ek2 = key_model(v[4], v[5], v[6], v[7]);
    ord = 4'h0; kk = 16'h0; na = 0; nk = 0;
    key_req = 1'b1; disp_req = 1'b1;
    for (int c = 0; c < 3000 && na < 4; c++) begin
      @(negedge clkIn);
      if (key_ack || disp_ack) begin
        ord = {ord[2:0], disp_ack};
        na++;
        if (key_ack && nk < 2) begin kk = {kk[7:0], keys}; nk++; end
      end
    end
    key_req = 1'b0; disp_req = 1'b0;
    repeat (8) @(negedge clkIn);
    n_cmp++;
    if (na !== 4 || ord !== 4'b0101) begin
      n_bad++; $display("FAIL b2b_order got %0d acks order %b want 4 acks order 0101 (key,disp,key,disp)", na, ord);
    end
    n_cmp++;
    if (kk !== {ek1, ek2}) begin n_bad++; $display("FAIL b2b_keys got %h want %h", kk, {ek1, ek2}); end
  endtask

  task automatic test_timeout();
    logic [7:0] v [4];
    logic [7:0] kb, ek, k_at;
    logic [1:0] csrw;
    int d, ka0, er0;
    bit got;
    for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
    ek = key_model(v[0], v[1], v[2], v[3]);
    rdq.delete();
    for (int i = 0; i < 4; i++) rdq.push_back(v[i]);
    kb = keys; ka0 = n_kack; er0 = n_err; d = -1; got = 0;
    stall = 1'b1;
    key_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clkIn);
      if (tm_latch) break;
    end
    for (int c = 1; c < 40; c++) begin
      @(negedge clkIn);
      if (err) begin d = c; break; end
    end
    csrw = {tm_cs, tm_rw}; k_at = keys;
    stall = 1'b0;
    n_cmp++;
    if (d !== 8 || csrw !== 2'b11) begin
      n_bad++; $display("FAIL timeout_err latch-to-err %0d want 8, cs/rw %b want 11", d, csrw);
    end
    n_cmp++;
    if (k_at !== kb) begin n_bad++; $display("FAIL timeout_keys got %h want unchanged %h", k_at, kb); end
    for (int c = 0; c < 300; c++) begin
      @(negedge clkIn);
      if (key_ack) begin got = 1; k_at = keys; break; end
    end
    key_req = 1'b0;
    repeat (6) @(negedge clkIn);
    n_cmp++;
    if (!got || k_at !== ek || n_kack - ka0 !== 1 || n_err - er0 !== 1) begin
      n_bad++;
      $display("FAIL timeout_retry keys %h want %h, acks %0d want 1, errs %0d want 1",
               k_at, ek, n_kack - ka0, n_err - er0);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] first;
    bit got;
    for (int i = 0; i < 16; i++) fbuf[i] = 8'($urandom);
    got = 0;
    disp_req = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clkIn);
      if (frame_addr == 4'd8) begin got = 1; break; end
    end
    rst = 1'b1; key_req = 1'b1;
    @(negedge clkIn);
    n_cmp++;
    if (!got || {tm_cs, tm_rw, tm_latch, tm_out, keys, key_ack, disp_ack, err, frame_addr} !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_mid reached=%0d got %h want %h", got,
               {tm_cs, tm_rw, tm_latch, tm_out, keys, key_ack, disp_ack, err, frame_addr}, RST_VEC);
    end
    @(negedge clkIn); rst = 1'b0;
    first = 2'b00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clkIn);
      if (key_ack || disp_ack) begin first = {key_ack, disp_ack}; break; end
    end
    key_req = 1'b0;
    n_cmp++;
    if (first !== 2'b10) begin n_bad++; $display("FAIL reset_mid_first_grant got %b want 10 (key first)", first); end
    got = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clkIn);
      if (disp_ack) begin got = 1; break; end
    end
    disp_req = 1'b0;
    repeat (6) @(negedge clkIn);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL reset_mid_disp_after got no disp_ack want one"); end
  endtask

  task automatic test_drop_after_grant();
    int fr0, da0;
    bit granted;
    fr0 = fr_id; da0 = n_dack; granted = 0;
    disp_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clkIn);
      if (!tm_cs) begin granted = 1; break; end
    end
    disp_req = 1'b0;
    repeat (200) @(negedge clkIn);
    n_cmp++;
    if (!granted || n_dack - da0 !== 1 || fr_id - fr0 !== 3 || tm_cs !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_after_grant acks %0d want 1, frames %0d want 3, tm_cs %b want 1",
               n_dack - da0, fr_id - fr0, tm_cs);
    end
    fr0 = fr_id;
    key_req = 1'b1; @(negedge clkIn); key_req = 1'b0;
    repeat (12) @(negedge clkIn);
    n_cmp++;
    if (fr_id - fr0 !== 0) begin n_bad++; $display("FAIL drop_before_grant frames %0d want 0", fr_id - fr0); end
  endtask

  task automatic test_protocol();
    @(negedge clkIn);
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL protocol_rules got %0d violations want 0", viol); end
  endtask

  initial begin
    rst = 1'b1; key_req = 1'b0; disp_req = 1'b0; disp_on = 1'b0; bright = 3'd0;
    for (int i = 0; i < 16; i++) fbuf[i] = 8'(i);
    test_reset();
    test_key_scan();
    test_display();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_drop_after_grant();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
